// File: rtl/mmio_bus_ctrl.sv
// ----------------------------------------------------------------------------
// mmio_bus_ctrl
//
// Memory-mapped I/O bus controller between the CPU data port and the MMIO
// peripherals. An access is accepted in IDLE. Its address ID field picks one
// slave through the SLV_IDS table, and the matching slave select stays high
// until that slave acks or the wait budget runs out. Every access ends with
// a single-cycle ready pulse that carries rdata and err. Unmapped and
// timed-out accesses count as bus errors in a saturating counter.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req, we           master request (sampled in IDLE only), 1 = write
//   addr, wdata       master address / write data
//   ready             one-cycle pulse: access complete
//   rdata, err        read data / bus error, valid while ready = 1
//   err_cnt           saturating bus-error count
//   s_sel             one-hot slave select
//   s_we, s_addr,     access attributes latched at accept time, held stable
//   s_wdata           for the whole WAIT phase
//   s_rdata           slave read data, slave i on [i*DW +: DW]
//   s_ack             slave completion strobes, only the selected one is used
// ----------------------------------------------------------------------------
module mmio_bus_ctrl #(
    parameter int unsigned          AW        = 32,
    parameter int unsigned          DW        = 32,
    parameter int unsigned          NSLV      = 8,
    parameter int unsigned          ID_LO     = 20,
    parameter int unsigned          ID_W      = 4,
    parameter logic [NSLV*ID_W-1:0] SLV_IDS   = {4'h8, 4'h7, 4'h6, 4'h5,
                                                 4'h4, 4'h3, 4'h2, 4'h1},
    // TIMEOUT must be at least 1.
    parameter int unsigned          TIMEOUT   = 15,
    parameter int unsigned          ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [DW-1:0]        wdata,
    output logic                 ready,
    output logic [DW-1:0]        rdata,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [NSLV-1:0]      s_sel,
    output logic                 s_we,
    output logic [AW-1:0]        s_addr,
    output logic [DW-1:0]        s_wdata,
    input  logic [NSLV*DW-1:0]   s_rdata,
    input  logic [NSLV-1:0]      s_ack
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NSLV-1:0]        sel_q, sel_d;
    logic                   we_q, we_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic [DW-1:0]          rdata_q, rdata_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [ID_W-1:0] id;
    logic [NSLV-1:0] hit;
    logic [NSLV-1:0] win;
    logic            miss;

    assign id = addr[ID_LO +: ID_W];

    always_comb begin
        hit = '0;
        for (int i = 0; i < NSLV; i++) begin
            hit[i] = (id == SLV_IDS[i*ID_W +: ID_W]);
        end
    end

    // x & -x keeps only the lowest set bit, so with duplicate table entries
    // the lowest slot index wins.
    assign win  = hit & (~hit + NSLV'(1));
    assign miss = ~|hit;

    // ------------------------------------------------------------------
    // Selected-slave response path
    // ------------------------------------------------------------------
    logic          sel_ack;
    logic [DW-1:0] sel_rdata;

    // Masking with the one-hot select makes acks from other slaves
    // invisible.
    assign sel_ack = |(s_ack & sel_q);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | s_rdata[i*DW +: DW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (miss) begin
                        // Unmapped: answer straight away and leave the
                        // latched slave-side attributes untouched.
                        rdata_d = '0;
                        err_d   = 1'b1;
                        ready_d = 1'b1;
                        state_d = StResp;
                    end else begin
                        addr_d  = addr;
                        we_d    = we;
                        wdata_d = wdata;
                        sel_d   = win;
                        cnt_d   = '0;
                        state_d = StWait;
                    end
                end
            end

            StWait: begin
                // The ack is tested first, so an ack that lands in the last
                // allowed cycle still completes normally.
                if (sel_ack) begin
                    rdata_d = we_q ? '0 : sel_rdata;
                    sel_d   = '0;
                    ready_d = 1'b1;
                    state_d = StResp;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    sel_d   = '0;
                    ready_d = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StResp: begin
                if (err_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
                    err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                end
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ready   = ready_q;
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign s_sel   = sel_q;
    assign s_we    = we_q;
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    sel_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(sel_q));

    ready_no_sel_a: assert property (@(posedge clk) disable iff (!rst_n)
        ready_q |-> (sel_q == '0));

    ready_in_resp_a: assert property (@(posedge clk) disable iff (!rst_n)
        ready_q |-> (state_q == StResp));

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mmio_bus_ctrl
//
// Bench for mmio_bus_ctrl with two instances:
//   dut 0: default ID table, TIMEOUT 15, 16-bit error counter
//   dut 1: slots 1 and 4 both hold ID 2, TIMEOUT 3, 4-bit error counter
//          (the narrow counter lets saturation be reached quickly)
// The access task derives the whole timeline of an access from its plan
// (target slot, ack cycle, timeout budget) and updates the expected outputs
// cycle by cycle. One negedge process compares both instances against those
// expectations. Literal checks after each access pin the model.
// ----------------------------------------------------------------------------
module tb_mmio_bus_ctrl;

    localparam int unsigned NSLV  = 8;
    localparam int unsigned DW    = 32;
    localparam logic [31:0] IDS_A = {4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    localparam logic [31:0] IDS_B = {4'h8, 4'h7, 4'h6, 4'h2, 4'h4, 4'h3, 4'h2, 4'h1};
    localparam int          TO_A  = 15;
    localparam int          TO_B  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic                 req     [2];
    logic                 we      [2];
    logic [31:0]          addr    [2];
    logic [31:0]          wdata   [2];
    logic [NSLV*DW-1:0]   s_rdata [2];
    logic [NSLV-1:0]      s_ack   [2];
    logic                 ready   [2];
    logic                 err     [2];
    logic [31:0]          rdata   [2];
    logic [NSLV-1:0]      s_sel   [2];
    logic                 s_we    [2];
    logic [31:0]          s_addr  [2];
    logic [31:0]          s_wdata [2];
    logic [15:0]          err_cnt_a;
    logic [3:0]           err_cnt_b;

    mmio_bus_ctrl #(
        .SLV_IDS (IDS_A),
        .TIMEOUT (TO_A)
    ) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req[0]),
        .we      (we[0]),
        .addr    (addr[0]),
        .wdata   (wdata[0]),
        .ready   (ready[0]),
        .rdata   (rdata[0]),
        .err     (err[0]),
        .err_cnt (err_cnt_a),
        .s_sel   (s_sel[0]),
        .s_we    (s_we[0]),
        .s_addr  (s_addr[0]),
        .s_wdata (s_wdata[0]),
        .s_rdata (s_rdata[0]),
        .s_ack   (s_ack[0])
    );

    mmio_bus_ctrl #(
        .SLV_IDS   (IDS_B),
        .TIMEOUT   (TO_B),
        .ERR_CNT_W (4)
    ) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req[1]),
        .we      (we[1]),
        .addr    (addr[1]),
        .wdata   (wdata[1]),
        .ready   (ready[1]),
        .rdata   (rdata[1]),
        .err     (err[1]),
        .err_cnt (err_cnt_b),
        .s_sel   (s_sel[1]),
        .s_we    (s_we[1]),
        .s_addr  (s_addr[1]),
        .s_wdata (s_wdata[1]),
        .s_rdata (s_rdata[1]),
        .s_ack   (s_ack[1])
    );

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Expected outputs, per instance
    logic        check_en = 1'b0;
    logic [7:0]  exp_sel    [2];
    logic        exp_ready  [2];
    logic        exp_err    [2];
    logic [31:0] exp_rdata  [2];
    logic        exp_swe    [2];
    logic [31:0] exp_saddr  [2];
    logic [31:0] exp_swdata [2];
    int          exp_cnt    [2];

    // Observations of the most recent access, for literal checks
    int          cap_ready_cyc;
    logic        cap_err;
    logic [7:0]  cap_sel1;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_sel[d]    = '0;
            exp_ready[d]  = 1'b0;
            exp_err[d]    = 1'b0;
            exp_rdata[d]  = '0;
            exp_swe[d]    = 1'b0;
            exp_saddr[d]  = '0;
            exp_swdata[d] = '0;
            exp_cnt[d]    = 0;
        end
    endtask

    function automatic int find_slot(input int d, input logic [31:0] a);
        logic [31:0] ids;
        ids = (d == 0) ? IDS_A : IDS_B;
        for (int i = 0; i < NSLV; i++) begin
            if (ids[i*4 +: 4] == a[23:20]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("dut%0d.ready", d),   64'(ready[d]),   64'(exp_ready[d]));
                chk($sformatf("dut%0d.err", d),     64'(err[d]),     64'(exp_err[d]));
                chk($sformatf("dut%0d.rdata", d),   64'(rdata[d]),   64'(exp_rdata[d]));
                chk($sformatf("dut%0d.s_sel", d),   64'(s_sel[d]),   64'(exp_sel[d]));
                chk($sformatf("dut%0d.s_we", d),    64'(s_we[d]),    64'(exp_swe[d]));
                chk($sformatf("dut%0d.s_addr", d),  64'(s_addr[d]),  64'(exp_saddr[d]));
                chk($sformatf("dut%0d.s_wdata", d), 64'(s_wdata[d]), 64'(exp_swdata[d]));
            end
            chk("dut0.err_cnt", 64'(err_cnt_a), 64'(exp_cnt[0]));
            chk("dut1.err_cnt", 64'(err_cnt_b), 64'(exp_cnt[1]));
        end
    end

    // ------------------------------------------------------------------
    // One access on instance d. ack_k is the cycle (counted from the first
    // cycle after the request edge) in which the target slave acks; values
    // outside 1..TIMEOUT mean it never acks in time. stray_idx acks in
    // cycle stray_k.
    // ------------------------------------------------------------------
    task automatic access(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input int ack_k,
                          input logic [31:0] ack_data, input int stray_k,
                          input int stray_idx);
        int          slot, to, end_w, done, cmax;
        logic        is_err;
        logic [31:0] resp;
        slot = find_slot(d, a);
        to   = (d == 0) ? TO_A : TO_B;
        cmax = (d == 0) ? 65535 : 15;
        if (slot < 0) begin
            end_w = 0; done = 1; is_err = 1'b1; resp = '0;
        end else if (ack_k >= 1 && ack_k <= to) begin
            end_w = ack_k; done = ack_k + 1; is_err = 1'b0; resp = w ? 32'h0 : ack_data;
        end else begin
            end_w = to; done = to + 1; is_err = 1'b1; resp = '0;
        end

        @(posedge clk); #1;
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        cap_ready_cyc = -1; cap_err = 1'b0; cap_sel1 = '0;

        for (int c = 1; c <= done + 1; c++) begin
            @(posedge clk); #1;
            // req stays high through WAIT/RESP, where it must be ignored;
            // the other inputs are scrambled to show the latches hold.
            req[d]   = (c <= done);
            we[d]    = ~w;
            addr[d]  = ~a;
            wdata[d] = ~wd;
            s_ack[d]   = '0;
            s_rdata[d] = {NSLV{~ack_data}};
            if (slot >= 0 && c == ack_k) begin
                s_ack[d][slot] = 1'b1;
                s_rdata[d][slot*DW +: DW] = ack_data;
            end
            if (c == stray_k) s_ack[d][stray_idx] = 1'b1;

            exp_sel[d] = (slot >= 0 && c <= end_w) ? 8'(1 << slot) : 8'h00;
            if (slot >= 0 && c == 1) begin
                exp_swe[d] = w; exp_saddr[d] = a; exp_swdata[d] = wd;
            end
            exp_ready[d] = (c == done);
            exp_err[d]   = (c == done) && is_err;
            if (c == done) exp_rdata[d] = resp;
            if (c == done + 1 && is_err && exp_cnt[d] < cmax) exp_cnt[d]++;

            if (c == 1) cap_sel1 = s_sel[d];
            if (ready[d] === 1'b1 && cap_ready_cyc < 0) begin
                cap_ready_cyc = c; cap_err = err[d];
            end
        end
        req[d] = 1'b0; s_ack[d] = '0;
    endtask

    task automatic async_reset_mid_wait();
        @(posedge clk); #1;
        check_en = 1'b0;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0050_0000; wdata[0] = 32'hA5A5_5A5A;
        s_ack[0] = '0;
        repeat (3) begin
            @(posedge clk); #1;
            req[0] = 1'b0;
        end
        chk("rst.sel_before", 64'(s_sel[0]), 64'(8'b0001_0000));
        chk("rst.cnt_before", 64'(err_cnt_a), 64'(exp_cnt[0]));
        #2 rst_n = 1'b0;
        #1;
        chk("rst.async_sel",    64'(s_sel[0]),  64'(0));
        chk("rst.async_ready",  64'(ready[0]),  64'(0));
        chk("rst.async_cnt_a",  64'(err_cnt_a), 64'(0));
        chk("rst.async_cnt_b",  64'(err_cnt_b), 64'(0));
        chk("rst.async_saddr",  64'(s_addr[0]), 64'(0));
        chk("rst.async_rdata1", 64'(rdata[1]),  64'(0));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_en = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
            s_rdata[d] = '0; s_ack[d] = '0;
        end
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset.ready",   64'(ready[0]),  64'(0));
        chk("reset.s_sel",   64'(s_sel[0]),  64'(0));
        chk("reset.err_cnt", 64'(err_cnt_a), 64'(0));
        check_en = 1'b1;

        // Timer read, ack in cycle 1
        access(0, 1'b0, 32'h0030_0010, 32'h0, 1, 32'hDEAD_BEEF, -1, 0);
        chk("t1.sel_c1",  64'(cap_sel1),      64'(8'b0000_0100));
        chk("t1.ready_c", 64'(cap_ready_cyc), 64'(2));
        chk("t1.err",     64'(cap_err),       64'(0));
        chk("t1.rdata",   64'(rdata[0]),      64'(32'hDEAD_BEEF));

        // dmem write, three wait cycles, ack in cycle 4
        access(0, 1'b1, 32'h0010_0004, 32'h1234_5678, 4, 32'h5555_AAAA, -1, 0);
        chk("t2.ready_c", 64'(cap_ready_cyc), 64'(5));
        chk("t2.rdata",   64'(rdata[0]),      64'(0));
        chk("t2.s_we",    64'(s_we[0]),       64'(1));
        chk("t2.s_wdata", 64'(s_wdata[0]),    64'(32'h1234_5678));

        // Unmapped ID A
        access(0, 1'b0, 32'h00A0_0000, 32'h0, 1, 32'h0, -1, 0);
        chk("t3.ready_c", 64'(cap_ready_cyc), 64'(1));
        chk("t3.err",     64'(cap_err),       64'(1));
        chk("t3.err_cnt", 64'(err_cnt_a),     64'(1));

        // Slave 3 never acks; stray ack on slave 5 mid-wait
        access(0, 1'b0, 32'h0040_0000, 32'h0, 0, 32'h0, 3, 5);
        chk("t4.ready_c", 64'(cap_ready_cyc), 64'(16));
        chk("t4.err",     64'(cap_err),       64'(1));
        chk("t4.err_cnt", 64'(err_cnt_a),     64'(2));

        // Ack on the last allowed cycle completes; one cycle later times out
        access(0, 1'b0, 32'h0080_00F0, 32'h0, 15, 32'h0BAD_F00D, -1, 0);
        chk("t5.ready_c", 64'(cap_ready_cyc), 64'(16));
        chk("t5.err",     64'(cap_err),       64'(0));
        access(0, 1'b0, 32'h0080_00F0, 32'h0, 16, 32'h0BAD_F00D, -1, 0);
        chk("t6.err",     64'(cap_err),       64'(1));
        chk("t6.err_cnt", 64'(err_cnt_a),     64'(3));

        // Duplicate ID 2 on dut 1: slot 1 wins; ack exactly on timeout cycle
        access(1, 1'b0, 32'h0020_0000, 32'h0, 3, 32'hCAFE_F00D, -1, 0);
        chk("t7.sel_c1",  64'(cap_sel1),      64'(8'b0000_0010));
        chk("t7.ready_c", 64'(cap_ready_cyc), 64'(4));
        chk("t7.err",     64'(cap_err),       64'(0));
        chk("t7.rdata",   64'(rdata[1]),      64'(32'hCAFE_F00D));
        // Only the losing duplicate (slot 4) acks: must time out
        access(1, 1'b0, 32'h0020_0000, 32'h0, 0, 32'h0, 1, 4);
        chk("t8.err",     64'(cap_err),       64'(1));

        async_reset_mid_wait();

        // Back to normal operation after reset
        access(0, 1'b0, 32'h0060_0008, 32'h0, 2, 32'h1357_9BDF, -1, 0);
        chk("t9.rdata", 64'(rdata[0]), 64'(32'h1357_9BDF));
        access(0, 1'b0, 32'h0000_0000, 32'h0, 1, 32'h0, -1, 0);
        chk("t9.err_cnt", 64'(err_cnt_a), 64'(1));

        // Saturate the narrow counter with unmapped accesses
        for (int i = 0; i < 17; i++) begin
            access(1, 1'b0, 32'h00F0_0000, 32'h0, 1, 32'h0, -1, 0);
        end
        chk("t10.sat", 64'(err_cnt_b), 64'(4'hF));

        repeat (2) @(posedge clk);
        #1 check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
- Parametrised memory-mapped I/O bus controller.
- Sits between the CPU data port and all MMIO peripherals (dmem, seg, timer, cmem, kbd, sw, led, fb, …).
- Decodes a configurable address ID field and drives a per-slave select with a req/ack handshake, so slaves may insert wait states.
- Registers read data, flags unmapped or timed-out accesses as bus errors, and counts errors.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- NSLV, 8, number of slave ports.
- ID_LO, 20, LSB of the ID field in addr.
- ID_W, 4, width of the ID field.
- SLV_IDS, {4'h8,4'h7,4'h6,4'h5,4'h4,4'h3,4'h2,4'h1}, packed NSLV*ID_W table. Slot i is bits [i*ID_W +: ID_W] and holds the ID that selects slave i.
- TIMEOUT, 15, maximum WAIT cycles before an access fails with a bus error. Must be ≥1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  master access request, sampled only in IDLE
- we  in  1  1 = write, 0 = read
- addr  in  AW  access address
- wdata  in  DW  write data
- ready  out  1  one-cycle pulse: access complete
- rdata  out  DW  read data, valid while ready=1
- err  out  1  bus error, valid while ready=1
- err_cnt  out  16  saturating count of bus errors
- s_sel  out  NSLV  one-hot slave select
- s_we  out  1  latched we
- s_addr  out  AW  latched addr
- s_wdata  out  DW  latched wdata
- s_rdata  in  NSLV*DW  slave read data; slave i on [i*DW +: DW]
- s_ack  in  NSLV  slave completion strobe

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - On rst_n=0: state←IDLE; ready, err, s_sel, s_we, s_addr, s_wdata, rdata, wait counter and err_cnt all ←0.
  - Applies immediately, including mid-access. An in-flight access is dropped silently: no ready pulse, no error count.
- Decode (combinational, IDLE only):
  - id = addr[ID_LO +: ID_W]; hit[i] = (id == SLV_IDS slot i).
  - If several slots match, the lowest index wins.
  - miss = no slot matches.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On req=1 with a hit: latch addr, we, wdata into s_addr/s_we/s_wdata; s_sel←onehot(winner); cnt←0; go WAIT.
  - On req=1 with a miss: rdata←0, err←1, s_sel stays 0; go RESP.
  - req=0: stay in IDLE.
- WAIT:
  - s_sel and latched outputs are held stable.
  - If s_ack at the selected index is 1: rdata←selected s_rdata if read, else 0; err←0; s_sel←0; go RESP.
  - Else if cnt == TIMEOUT-1: rdata←0, err←1, s_sel←0; go RESP.
  - Else cnt←cnt+1.
  - Acks on non-selected indices are ignored.
  - An ack in the same cycle as the timeout condition wins: normal completion.
- RESP:
  - ready=1 for exactly one cycle; rdata/err valid during that cycle.
  - If err=1, err_cnt←err_cnt+1, saturating at 16'hFFFF.
  - Next state IDLE. In the following cycle ready←0, err←0; rdata holds its value.
- Latency: req at cycle 0 → s_sel high at cycle 1.
  - Slave acks in cycle k ≥ 1 → ready in cycle k+1. Minimum 2 cycles.
  - Miss → ready at cycle 1.
  - Timeout → ready at cycle TIMEOUT+1.
- req high in WAIT/RESP is ignored. The master must re-present the request after ready; back-to-back accesses are possible no sooner than the cycle after RESP.
- Counter width: $clog2(TIMEOUT+1); no wrap.

Test Plan:
- Reset, then read addr=32'h0030_0010, timer slave (index 2) acks at cycle 1 with 32'hDEAD_BEEF → s_sel=8'b0000_0100 at cycle 1, ready=1, rdata=32'hDEAD_BEEF, err=0 at cycle 2.
- Write addr=32'h0010_0004, wdata=32'h1234_5678; dmem (index 0) acks after 3 wait cycles → s_we=1, s_addr and s_wdata stable throughout WAIT; ready at cycle 5; rdata=0, err=0.
- Access addr=32'h00A0_0000 (ID A unmapped) → s_sel stays 0, ready=1 with err=1 and rdata=0 at cycle 1; err_cnt=1.
- Read on index 3 with no ack, TIMEOUT=15 → ready=1, err=1 at cycle 16; s_sel drops the same edge; a stray s_ack[5] during WAIT has no effect.
- SLV_IDS with slots 1 and 4 both 4'h2, access ID 2 → s_sel=8'b0000_0010; s_ack arriving exactly on the timeout cycle → err=0.
- Assert rst_n=0 asynchronously mid-WAIT → s_sel, ready, err_cnt go 0 without a clock edge. Then drive 65,536 unmapped accesses → err_cnt saturates at 16'hFFFF.
